// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed 7-segment scan driver:
//   - scan_state_e  : per-slot scan FSM encoding (IDLE/BLANK/ON/OFF)
//   - SEG_*         : bit positions inside a segment byte {p,g,f,e,d,c,b,a}
//   - HEX_SEG_TABLE : 16-entry hex digit -> segment pattern (1 = lit, dp clear)
//   - hex_to_seg()  : table lookup with decimal point merged into bit 7
// ---------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_OFF   = 2'd3
    } scan_state_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_P = 7;

    // Element [n] holds the pattern for hex digit n (listed F down to 0).
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39,   // F E d C
        8'h7C, 8'h77, 8'h6F, 8'h7F,   // b A 9 8
        8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
        8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex, input logic dp);
        logic [7:0] pat;
        pat        = HEX_SEG_TABLE[hex];
        pat[SEG_P] = dp;
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex-to-7-segment decoder, used by display_scan_mux only when
// HEX_DECODE_EN is defined.
// Ports:
//   hex_i [3:0] : hex digit 0..F
//   dp_i        : decimal point request
//   seg_o [7:0] : segment pattern {p,g,f,e,d,c,b,a}, 1 = lit
// ---------------------------------------------------------------------------
module seg7_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i, dp_i);

endmodule

// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------
// display_scan_mux
// Multiplexed 7-segment driver: scans NUM_DIGITS common-pin digits over one
// segment bus. Each digit owns a slot of CLK_DIV cycles: BLANK_CYC cycles with
// every digit off (anti-ghosting), then an ON window of Dim_s*STEP cycles,
// then OFF until the slot ends. Digit data is double-buffered: Update writes
// the pending buffer, which is copied to the displayed buffer only at a frame
// boundary so a frame never tears.
//
// Build option: HEX_DECODE_EN -- when defined, each SegIn byte carries a hex
// nibble (bits 3:0) and a decimal point (bit 4) which are decoded to a
// segment pattern; when undefined, bytes are raw segment patterns.
//
// Ports:
//   Clk        : system clock, rising edge
//   Rst        : asynchronous reset, active-high
//   Enable     : 0 = display dark, scan held at digit 0
//   Update     : 1-cycle pulse, capture SegIn into the pending buffer
//   SegIn      : byte k = digit k, {p,g,f,e,d,c,b,a}, 1 = lit
//   Dim        : brightness 0..15, sampled at slot start
//   SEG        : segment pins, polarity per SEG_ACT_LOW
//   DIG        : digit select pins, one-hot when lit, polarity per DIG_ACT_LOW
//   FrameStart : 1-cycle pulse in the first cycle of the digit 0 slot
// ---------------------------------------------------------------------------
module display_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 1000,
    parameter int BLANK_CYC   = 16,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Enable,
    input  logic                    Update,
    input  logic [NUM_DIGITS*8-1:0] SegIn,
    input  logic [3:0]              Dim,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   DIG,
    output logic                    FrameStart
);

    localparam int STEP  = (CLK_DIV - BLANK_CYC) / 16;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [7:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

    scan_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [3:0]           dim_s_q;
    logic [7:0]           seg_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic                 fs_q;

    logic                    slot_end_d;
    logic                    frame_load_d;
    logic [3:0]              dim_eff_d;
    logic [CNT_W-1:0]        on_last_d;
    logic [NUM_DIGITS*8-1:0] active_flat_d;
    logic [7:0]              seg_raw_d;
    logic [7:0]              seg_pat_d;
    logic [7:0]              seg_lit_d;
    logic [NUM_DIGITS-1:0]   dig_lit_d;

    // -----------------------------------------------------------------------
    // Slot timing helpers
    // -----------------------------------------------------------------------
    assign slot_end_d = (cnt_q == CNT_LAST);

    // Dim_s is being loaded during cnt==0, so use the live input there; this
    // keeps the BLANK->ON decision correct even for a one-cycle blank.
    assign dim_eff_d = (cnt_q == '0) ? Dim : dim_s_q;

    // Last counter value of the ON window (only meaningful when Dim_s > 0).
    assign on_last_d = CNT_W'(BLANK_CYC) + CNT_W'(dim_s_q) * CNT_W'(STEP) - CNT_W'(1);

    // Frame boundary: leaving IDLE, or wrapping from the last digit to digit 0.
    assign frame_load_d = Enable &&
                          ((state_q == ST_IDLE) ||
                           (slot_end_d && (idx_q == IDX_LAST)));

    // -----------------------------------------------------------------------
    // Double-buffered digit data. A coincident Update and frame load writes
    // SegIn straight into the active buffer so the newest data is shown.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_buf
            logic [7:0] pending_q;
            logic [7:0] active_q;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    pending_q <= '0;
                    active_q  <= '0;
                end else begin
                    if (Update) begin
                        pending_q <= SegIn[gi*8 +: 8];
                    end
                    if (frame_load_d) begin
                        active_q <= Update ? SegIn[gi*8 +: 8] : pending_q;
                    end
                end
            end

            assign active_flat_d[gi*8 +: 8] = active_q;
        end
    endgenerate

    assign seg_raw_d = active_flat_d[{idx_q, 3'b000} +: 8];

    // Decode sits between the active buffer and the output register.
`ifdef HEX_DECODE_EN
    seg7_hex_decode u_hex_decode (
        .hex_i (seg_raw_d[3:0]),
        .dp_i  (seg_raw_d[4]),
        .seg_o (seg_pat_d)
    );
`else
    assign seg_pat_d = seg_raw_d;
`endif

    assign seg_lit_d = (SEG_ACT_LOW != 0) ? ~seg_pat_d : seg_pat_d;
    assign dig_lit_d = (DIG_ACT_LOW != 0) ? ~(NUM_DIGITS'(1) << idx_q)
                                          :  (NUM_DIGITS'(1) << idx_q);

    // -----------------------------------------------------------------------
    // Scan FSM, counters and registered pins. Pins reflect the state of the
    // previous cycle, except that Enable=0 darkens them on the very next edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dim_s_q <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            fs_q    <= 1'b0;
        end else begin
            // Only the ON state drives a digit, so at most one DIG is active
            // and BLANK always separates two lit digits.
            if (Enable && (state_q == ST_ON)) begin
                seg_q <= seg_lit_d;
                dig_q <= dig_lit_d;
            end else begin
                seg_q <= SEG_OFF;
                dig_q <= DIG_OFF;
            end
            fs_q <= Enable && (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == '0);

            if (!Enable) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else if (state_q == ST_IDLE) begin
                state_q <= ST_BLANK;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                if (cnt_q == '0) begin
                    dim_s_q <= Dim;
                end
                if (slot_end_d) begin
                    state_q <= ST_BLANK;
                    cnt_q   <= '0;
                    idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    case (state_q)
                        ST_BLANK: begin
                            if (cnt_q == BLANK_LAST) begin
                                state_q <= (dim_eff_d != 4'd0) ? ST_ON : ST_OFF;
                            end
                        end
                        ST_ON: begin
                            if (cnt_q == on_last_d) begin
                                state_q <= ST_OFF;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign SEG        = seg_q;
    assign DIG        = dig_q;
    assign FrameStart = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_display_scan_mux
// Directed bench for display_scan_mux with NUM_DIGITS=4, CLK_DIV=20,
// BLANK_CYC=4 (STEP=1), active-low SEG and DIG. A frame is 80 cycles; frames
// are captured starting at the cycle where FrameStart is seen high, so slot s
// occupies samples 20*s..20*s+19, blank at positions 0..3 and ON at
// positions 4..(4+Dim-1).
// ---------------------------------------------------------------------------
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        update;
    logic [31:0] seg_in;
    logic [3:0]  dim;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    logic [3:0] dig_log [80];
    logic [7:0] seg_log [80];
    logic       fs_log  [80];

    always #5 clk = ~clk;

    display_scan_mux #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (20),
        .BLANK_CYC   (4),
        .SEG_ACT_LOW (1),
        .DIG_ACT_LOW (1)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Enable     (enable),
        .Update     (update),
        .SegIn      (seg_in),
        .Dim        (dim),
        .SEG        (seg),
        .DIG        (dig),
        .FrameStart (frame_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a FrameStart pulse; returns at once if it is high now.
    task automatic wait_fs(input string name);
        int n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_fs: FrameStart=%b after %0d cycles, required 1", name, frame_start, n);
        end
    endtask

    // Record one 80-cycle frame. Optionally pulse Update with new data at
    // sample upd_k and change Dim at sample dim_k (-1 = no change).
    task automatic capture(input int upd_k, input logic [31:0] upd_val,
                           input int dim_k, input logic [3:0] dim_val);
        for (int k = 0; k < 80; k++) begin
            dig_log[k] = dig;
            seg_log[k] = seg;
            fs_log[k]  = frame_start;
            if (k == dim_k) dim = dim_val;
            if (k == upd_k) begin
                seg_in = upd_val;
                update = 1'b1;
            end else begin
                update = 1'b0;
            end
            tick();
        end
        update = 1'b0;
    endtask

    function automatic logic [3:0] exp_dig(int k, int on_len);
        int s = k / 20;
        int p = k % 20;
        logic [3:0] one;
        one = 4'b0001 << s;
        if (p >= 4 && p < 4 + on_len) return ~one;
        return 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg(int k, int on_len, logic [7:0] b);
        int p = k % 20;
        if (p >= 4 && p < 4 + on_len) return ~b;
        return 8'hFF;
    endfunction

    // First sample of slot s that disagrees with the expected waveform, or -1.
    function automatic int first_bad(int s, int on_len, logic [7:0] b);
        for (int p = 0; p < 20; p++) begin
            int k = s * 20 + p;
            logic fs_exp;
            fs_exp = (k == 0);
            if (dig_log[k] !== exp_dig(k, on_len) || seg_log[k] !== exp_seg(k, on_len, b) ||
                fs_log[k] !== fs_exp)
                return k;
        end
        return -1;
    endfunction

    // -----------------------------------------------------------------------
    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; enable = 1'b0; update = 1'b0; seg_in = '0; dim = '0;
        repeat (3) tick();
        checks++;
        if (dig !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_in: DIG=%h SEG=%h FS=%b, required F FF 0", dig, seg, frame_start);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dig !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad cycles, last DIG=%h SEG=%h FS=%b, required F FF 0", bad, dig, seg, frame_start);
        end
        $display("test_reset done");
    endtask

    task automatic test_scan();
        logic [31:0] data = 32'h4F5B0673;
        seg_in = data; update = 1'b1; tick(); update = 1'b0;
        dim = 4'd15; enable = 1'b1;
        wait_fs("scan");
        capture(-1, '0, -1, '0);
        for (int s = 0; s < 4; s++) begin
            int kb = first_bad(s, 15, data[8*s +: 8]);
            checks++;
            if (kb != -1) begin
                errors++;
                $display("FAIL scan_slot%0d: k=%0d DIG=%h SEG=%h FS=%b required DIG=%h SEG=%h",
                         s, kb, dig_log[kb], seg_log[kb], fs_log[kb], exp_dig(kb, 15), exp_seg(kb, 15, data[8*s +: 8]));
            end
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL scan_frame_period: FrameStart=%b at cycle 80, required 1", frame_start);
        end
        $display("test_scan done");
    endtask

    task automatic test_dim();
        logic [31:0] data = 32'h4F5B0673;
        int on_a [4] = '{15, 4, 4, 4};
        int on_b [4] = '{4, 0, 0, 0};
        capture(-1, '0, 5, 4'd4);
        for (int s = 0; s < 4; s++) begin
            int kb = first_bad(s, on_a[s], data[8*s +: 8]);
            checks++;
            if (kb != -1) begin
                errors++;
                $display("FAIL dim4_slot%0d: k=%0d DIG=%h SEG=%h required DIG=%h SEG=%h",
                         s, kb, dig_log[kb], seg_log[kb], exp_dig(kb, on_a[s]), exp_seg(kb, on_a[s], data[8*s +: 8]));
            end
        end
        dim = 4'd0;
        capture(-1, '0, -1, '0);
        for (int s = 0; s < 4; s++) begin
            int kb = first_bad(s, on_b[s], data[8*s +: 8]);
            checks++;
            if (kb != -1) begin
                errors++;
                $display("FAIL dim0_slot%0d: k=%0d DIG=%h SEG=%h required DIG=%h SEG=%h",
                         s, kb, dig_log[kb], seg_log[kb], exp_dig(kb, on_b[s]), exp_seg(kb, on_b[s], data[8*s +: 8]));
            end
        end
        $display("test_dim done");
    endtask

    task automatic test_update();
        logic [31:0] exp_frame [3] = '{32'h4F5B0673, 32'hFFFFFFFF, 32'h01020408};
        dim = 4'd15;
        tick();
        wait_fs("update");
        for (int f = 0; f < 3; f++) begin
            logic [31:0] data = exp_frame[f];
            if (f == 0)      capture(25, 32'hFFFFFFFF, -1, '0);  // mid-frame, during digit 1
            else if (f == 1) capture(78, 32'h01020408, -1, '0);  // lands on the wrap edge
            else             capture(-1, '0, -1, '0);
            for (int s = 0; s < 4; s++) begin
                int kb = first_bad(s, 15, data[8*s +: 8]);
                checks++;
                if (kb != -1) begin
                    errors++;
                    $display("FAIL update_f%0d_slot%0d: k=%0d DIG=%h SEG=%h required DIG=%h SEG=%h",
                             f, s, kb, dig_log[kb], seg_log[kb], exp_dig(kb, 15), exp_seg(kb, 15, data[8*s +: 8]));
                end
            end
        end
        $display("test_update done");
    endtask

    task automatic test_enable();
        logic [31:0] data = 32'h01020408;
        int bad = 0;
        repeat (46) tick();                      // slot 2, position 6: ON
        checks++;
        if (dig !== 4'hB || seg !== 8'hFD) begin
            errors++;
            $display("FAIL enable_on_digit2: DIG=%h SEG=%h, required B FD", dig, seg);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (dig !== 4'hF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL enable_off_next: DIG=%h SEG=%h, required F FF", dig, seg);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dig !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_dark_hold: %0d bad cycles, required F FF 0", bad);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b0 || dig !== 4'hF) begin
            errors++;
            $display("FAIL reenable_first: FS=%b DIG=%h, required 0 F", frame_start, dig);
        end
        tick();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reenable_fs: FS=%b, required 1", frame_start);
        end
        capture(-1, '0, -1, '0);
        for (int s = 0; s < 4; s++) begin
            int kb = first_bad(s, 15, data[8*s +: 8]);
            checks++;
            if (kb != -1) begin
                errors++;
                $display("FAIL reenable_slot%0d: k=%0d DIG=%h SEG=%h required DIG=%h SEG=%h",
                         s, kb, dig_log[kb], seg_log[kb], exp_dig(kb, 15), exp_seg(kb, 15, data[8*s +: 8]));
            end
        end
        // Asynchronous reset in the middle of digit 0's ON window.
        repeat (6) tick();
        checks++;
        if (dig !== 4'hE) begin
            errors++;
            $display("FAIL rst_pre_on: DIG=%h, required E", dig);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dig !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: DIG=%h SEG=%h FS=%b, required F FF 0", dig, seg, frame_start);
        end
        tick(); tick();
        rst = 1'b0;
        wait_fs("after_rst");
        capture(-1, '0, -1, '0);
        for (int s = 0; s < 4; s++) begin
            int kb = first_bad(s, 15, 8'h00);   // buffers cleared by reset
            checks++;
            if (kb != -1) begin
                errors++;
                $display("FAIL after_rst_slot%0d: k=%0d DIG=%h SEG=%h required DIG=%h SEG=%h",
                         s, kb, dig_log[kb], seg_log[kb], exp_dig(kb, 15), exp_seg(kb, 15, 8'h00));
            end
        end
        $display("test_enable done");
    endtask

    task automatic test_hex();
        logic [7:0] exp_b0;
        int kb;
        int multi = 0;
`ifdef HEX_DECODE_EN
        exp_b0 = 8'hF7;    // 'A' with decimal point
`else
        exp_b0 = 8'h1A;    // raw pattern passes unchanged
`endif
        seg_in = 32'h4F5B061A; update = 1'b1; tick(); update = 1'b0;
        tick();
        wait_fs("hex");
        capture(-1, '0, -1, '0);
        kb = first_bad(0, 15, exp_b0);
        checks++;
        if (kb != -1) begin
            errors++;
            $display("FAIL hex_slot0: k=%0d DIG=%h SEG=%h required DIG=%h SEG=%h",
                     kb, dig_log[kb], seg_log[kb], exp_dig(kb, 15), exp_seg(kb, 15, exp_b0));
        end
        for (int k = 0; k < 80; k++) begin
            if ($countones(~dig_log[k]) > 1) multi++;
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL onehot_dig: %0d samples with more than one active digit, required 0", multi);
        end
        $display("test_hex done");
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; update = 1'b0; seg_in = '0; dim = '0;
        test_reset();
        test_scan();
        test_dim();
        test_update();
        test_enable();
        test_hex();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
